// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet receive constants and state type
package eth_pkg;

   localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
   localparam logic [7:0]  ETH_SFD         = 8'hD5;
   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
   localparam logic [47:0] ETH_BCAST       = 48'hFFFF_FFFF_FFFF;
   localparam logic [10:0] ETH_LEN_SAT     = 11'd2047;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_DISCARD
   } rx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - combinational reflected CRC-32 update for one byte
module crc32_d8
   import eth_pkg::*;
(
   input  logic [31:0] i_crc,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);

   logic [31:0] w_crc;

   always_comb begin
      w_crc = i_crc ^ {24'h0, i_data};
      for (int i = 0; i < 8; i++) begin
         w_crc = w_crc[0] ? ((w_crc >> 1) ^ CRC32_POLY_REFL) : (w_crc >> 1);
      end
   end

   assign o_crc = w_crc;

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// rtl/eth_rx_frame_ctrl.sv - GMII receive frame controller: preamble/SFD, DA filter,
// FCS strip via 5-byte delay line, CRC and length verdict on the last byte
module eth_rx_frame_ctrl
   import eth_pkg::*;
#(
   parameter logic [47:0] LOCAL_MAC = 48'h0011_2233_4455,
   parameter int          MIN_LEN   = 64,
   parameter int          MAX_LEN   = 1518
) (
   input  logic        gmii_rx_clk,
   input  logic        rst,
   input  logic        gmii_rx_dv,
   input  logic [7:0]  gmii_rxd,
   input  logic        cfg_promisc,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        rx_sof,
   output logic        rx_eof,
   output logic        rx_good,
   output logic [10:0] rx_len,
   output logic        rx_drop
);

   localparam logic [10:0] MIN_L = 11'(MIN_LEN);
   localparam logic [10:0] MAX_L = 11'(MAX_LEN);

   rx_state_t   r_state;
   logic [31:0] r_crc;
   logic [10:0] r_count;
   logic [7:0]  r_sr [5];
   logic [2:0]  r_fill;
   logic        r_first;

   logic [7:0]  r_data;
   logic        r_valid;
   logic        r_sof;
   logic        r_eof;
   logic        r_good;
   logic [10:0] r_len;
   logic        r_drop;

   logic [31:0] w_crc_next;
   logic [47:0] w_da;
   logic        w_da_ok;
   logic        w_len_ok;
   logic        w_full;

   crc32_d8 u_crc (
      .i_crc  (r_crc),
      .i_data (gmii_rxd),
      .o_crc  (w_crc_next)
   );

   // Oldest delay-line byte is the first DA byte; the incoming byte completes the DA.
   assign w_da     = {r_sr[4], r_sr[3], r_sr[2], r_sr[1], r_sr[0], gmii_rxd};
   assign w_da_ok  = cfg_promisc || (w_da == LOCAL_MAC) || (w_da == ETH_BCAST);
   assign w_len_ok = (r_count >= MIN_L) && (r_count <= MAX_L);
   assign w_full   = (r_fill == 3'd5);

   always_ff @(posedge gmii_rx_clk) begin
      if (rst) begin
         // A burst already in flight is ignored until the line goes quiet.
         r_state <= gmii_rx_dv ? ST_DISCARD : ST_IDLE;
         r_crc   <= CRC32_INIT;
         r_count <= '0;
         r_fill  <= '0;
         r_first <= 1'b1;
         for (int i = 0; i < 5; i++) r_sr[i] <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_sof   <= 1'b0;
         r_eof   <= 1'b0;
         r_good  <= 1'b0;
         r_len   <= '0;
         r_drop  <= 1'b0;
      end else begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_sof   <= 1'b0;
         r_eof   <= 1'b0;
         r_good  <= 1'b0;
         r_len   <= '0;
         r_drop  <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (gmii_rx_dv) begin
                  r_state <= (gmii_rxd == ETH_PREAMBLE) ? ST_PREAMBLE : ST_DISCARD;
               end
            end

            ST_PREAMBLE: begin
               if (!gmii_rx_dv) begin
                  r_state <= ST_IDLE;
               end else if (gmii_rxd == ETH_SFD) begin
                  r_state <= ST_DATA;
                  r_crc   <= CRC32_INIT;
                  r_count <= '0;
                  r_fill  <= '0;
                  r_first <= 1'b1;
               end else if (gmii_rxd != ETH_PREAMBLE) begin
                  r_state <= ST_DISCARD;
               end
            end

            ST_DATA: begin
               if (gmii_rx_dv) begin
                  r_crc <= w_crc_next;
                  if (r_count != ETH_LEN_SAT) r_count <= r_count + 11'd1;
                  for (int i = 4; i > 0; i--) r_sr[i] <= r_sr[i-1];
                  r_sr[0] <= gmii_rxd;
                  if (!w_full) r_fill <= r_fill + 3'd1;

                  if (w_full) begin
                     if (r_first && !w_da_ok) begin
                        r_drop  <= 1'b1;
                        r_state <= ST_DISCARD;
                     end else begin
                        r_valid <= 1'b1;
                        r_data  <= r_sr[4];
                        r_sof   <= r_first;
                        r_first <= 1'b0;
                     end
                  end
               end else begin
                  // On dv low the delay line holds one data byte plus the FCS.
                  if (w_full) begin
                     r_valid <= 1'b1;
                     r_data  <= r_sr[4];
                     r_sof   <= r_first;
                     r_eof   <= 1'b1;
                     r_len   <= r_count;
                     r_good  <= (r_crc == CRC32_RESIDUE) && w_len_ok;
                  end else begin
                     r_drop  <= 1'b1;
                  end
                  r_first <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end

            ST_DISCARD: begin
               if (!gmii_rx_dv) r_state <= ST_IDLE;
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign rx_data  = r_data;
   assign rx_valid = r_valid;
   assign rx_sof   = r_sof;
   assign rx_eof   = r_eof;
   assign rx_good  = r_good;
   assign rx_len   = r_len;
   assign rx_drop  = r_drop;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// tb/tb_eth_rx_frame_ctrl.sv - scoreboard bench for eth_rx_frame_ctrl
module tb_eth_rx_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        dv;
   logic [7:0]  rxd;
   logic        promisc;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_sof;
   logic        rx_eof;
   logic        rx_good;
   logic [10:0] rx_len;
   logic        rx_drop;

   always #5 clk = ~clk;

   eth_rx_frame_ctrl dut (
      .gmii_rx_clk (clk),
      .rst         (rst),
      .gmii_rx_dv  (dv),
      .gmii_rxd    (rxd),
      .cfg_promisc (promisc),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_sof      (rx_sof),
      .rx_eof      (rx_eof),
      .rx_good     (rx_good),
      .rx_len      (rx_len),
      .rx_drop     (rx_drop)
   );

   typedef struct {
      logic [7:0]  data;
      logic        sof;
      logic        eof;
      logic        good;
      logic [10:0] len;
   } exp_t;

   exp_t        exp_q[$];
   int          exp_drops = 0;
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  frm [0:2047];
   int          frm_len;

   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] LMAC  = 48'h0011_2233_4455;
   localparam logic [47:0] OTHER = 48'h0200_0000_0001;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Bit-serial reference CRC, one input bit at a time.
   function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] d);
      logic fb;
      for (int j = 0; j < 8; j++) begin
         fb = c[0] ^ d[j];
         c  = c >> 1;
         if (fb) c = c ^ 32'hEDB88320;
      end
      return c;
   endfunction

   task automatic build(input logic [47:0] da, input int n, input int flip_idx);
      logic [31:0] c;
      logic [31:0] fcs;
      for (int i = 0; i < 6; i++) frm[i] = da[47-8*i -: 8];
      frm[6] = 8'h02; frm[7] = 8'h00; frm[8] = 8'h00;
      frm[9] = 8'h00; frm[10] = 8'h00; frm[11] = 8'hAA;
      frm[12] = 8'h08; frm[13] = 8'h00;
      for (int i = 14; i < n - 4; i++) frm[i] = 8'(i * 7 + 3);
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n - 4; i++) c = crc_bits(c, frm[i]);
      fcs = ~c;
      frm[n-4] = fcs[7:0];
      frm[n-3] = fcs[15:8];
      frm[n-2] = fcs[23:16];
      frm[n-1] = fcs[31:24];
      if (flip_idx >= 0) frm[flip_idx] = frm[flip_idx] ^ 8'h10;
      frm_len = n;
   endtask

   task automatic push_frame(input logic good, input int count);
      exp_t e;
      for (int i = 0; i < count; i++) begin
         e.data = frm[i];
         e.sof  = (i == 0);
         e.eof  = (i == frm_len - 5) && (count == frm_len - 4);
         e.good = good;
         e.len  = 11'((frm_len > 2047) ? 2047 : frm_len);
         exp_q.push_back(e);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] b);
      dv  = v;
      rxd = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_pre();
      for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
      drive(1'b1, 8'hD5);
   endtask

   task automatic send_frame(input int gap);
      send_pre();
      for (int i = 0; i < frm_len; i++) drive(1'b1, frm[i]);
      for (int i = 0; i < gap; i++) drive(1'b0, 8'h00);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rx_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", {24'h0, rx_data}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("data", {24'h0, rx_data}, {24'h0, e.data});
            chk("sof", {31'h0, rx_sof}, {31'h0, e.sof});
            chk("eof", {31'h0, rx_eof}, {31'h0, e.eof});
            if (e.eof) begin
               chk("good", {31'h0, rx_good}, {31'h0, e.good});
               chk("len", {21'h0, rx_len}, {21'h0, e.len});
            end
         end
      end
      if (rx_drop) begin
         chk("drop_expected", {31'h0, exp_drops > 0}, 32'h1);
         chk("drop_eof_excl", {31'h0, rx_eof}, 32'h0);
         if (exp_drops > 0) exp_drops--;
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] c;
      rst = 1'b1; dv = 1'b0; rxd = 8'h00; promisc = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'h0, rx_valid}, 32'h0);
      chk("rst_sof",   {31'h0, rx_sof},   32'h0);
      chk("rst_eof",   {31'h0, rx_eof},   32'h0);
      chk("rst_good",  {31'h0, rx_good},  32'h0);
      chk("rst_drop",  {31'h0, rx_drop},  32'h0);
      chk("rst_len",   {21'h0, rx_len},   32'h0);
      chk("rst_data",  {24'h0, rx_data},  32'h0);
      rst = 1'b0;
      drive(1'b0, 8'h00);

      // Reference CRC against the standard check value of "123456789".
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < 9; i++) c = crc_bits(c, 8'(8'h31 + i));
      chk("crc_model_check", ~c, 32'hCBF43926);

      build(BCAST, 64, -1);     push_frame(1'b1, 60); send_frame(3);
      build(BCAST, 64, 30);     push_frame(1'b0, 60); send_frame(3);

      build(OTHER, 64, -1);     exp_drops++;          send_frame(3);
      promisc = 1'b1;
      build(OTHER, 64, -1);     push_frame(1'b1, 60); send_frame(3);
      promisc = 1'b0;

      build(LMAC, 100, -1);     push_frame(1'b1, 96); send_frame(1);
      build(LMAC, 63, -1);      push_frame(1'b0, 59); send_frame(1);

      exp_drops++;
      send_pre();
      drive(1'b1, 8'hFF); drive(1'b1, 8'hFF); drive(1'b1, 8'hFF);
      drive(1'b0, 8'h00); drive(1'b0, 8'h00);

      drive(1'b1, 8'h55); drive(1'b1, 8'h55); drive(1'b1, 8'h5D);
      drive(1'b1, 8'h55); drive(1'b1, 8'hD5);
      for (int i = 0; i < 12; i++) drive(1'b1, 8'hFF);
      drive(1'b0, 8'h00); drive(1'b0, 8'h00);

      build(BCAST, 1518, -1);   push_frame(1'b1, 1514); send_frame(2);
      build(BCAST, 1600, -1);   push_frame(1'b0, 1596); send_frame(2);

      // Reset lands on the edge sampling frame byte 20; bytes 0..14 are already out.
      build(BCAST, 64, -1);     push_frame(1'b0, 15);
      send_pre();
      for (int i = 0; i < 20; i++) drive(1'b1, frm[i]);
      rst = 1'b1;
      drive(1'b1, frm[20]);
      rst = 1'b0;
      chk("rst_mid_valid", {31'h0, rx_valid}, 32'h0);
      chk("rst_mid_eof",   {31'h0, rx_eof},   32'h0);
      chk("rst_mid_drop",  {31'h0, rx_drop},  32'h0);
      for (int i = 21; i < 64; i++) drive(1'b1, frm[i]);
      drive(1'b0, 8'h00);
      build(LMAC, 64, -1);      push_frame(1'b1, 60); send_frame(1);
      build(BCAST, 70, -1);     push_frame(1'b1, 66); send_frame(20);

      chk("exp_queue_empty", exp_q.size(), 32'h0);
      chk("drops_remaining", exp_drops, 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
